rsa_host_ctrl: RTL and testbench

//   Initiator side of the rsa_unit operand/result interface. Captures one operand set
//   (P, E, M) from the host on start and validates it. Computes the Montgomery constant

---
 rtl/rsa_host_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_rsa_host_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_host_ctrl.sv
// Purpose : host-side initiator for rsa_unit; captures/validates P,E,M, precomputes Const, runs the op.
// Latency : start -> done = 1 + 1 + 2*(WIDTH+2) + eoc wait + 1 cycles; errors surface 2 cycles after start.
// Backpress: single outstanding op; start is only sampled in IDLE and is dropped (not queued) while busy.
module rsa_host_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic [WIDTH-1:0] P_in,
  input  logic [WIDTH-1:0] E_in,
  input  logic [WIDTH-1:0] M_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [WIDTH-1:0] C_out,
  output logic             rsa_en,
  output logic [WIDTH-1:0] rsa_P,
  output logic [WIDTH-1:0] rsa_E,
  output logic [WIDTH-1:0] rsa_M,
  output logic [WIDTH-1:0] rsa_Const,
  input  logic [WIDTH-1:0] rsa_C,
  input  logic             rsa_eoc
);

  localparam int CW   = 16;
  localparam int RW   = WIDTH + 1;
  localparam int ITER = 2 * (WIDTH + 2);

  localparam logic [CW-1:0] ITER_LAST = CW'(ITER - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_MOD  = 2'b01;
  localparam logic [1:0] ERR_PGEM = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_PRECOMP = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] const_q, const_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [RW-1:0]    r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  // Shift-subtract step: r < M always holds, so 2r < 2M and one conditional subtract suffices.
  logic [WIDTH+1:0] r_dbl;
  logic [WIDTH+1:0] m_ext;
  logic             r_ge;
  logic [RW-1:0]    r_next;

  // One modular doubling of the running remainder.
  always_comb begin
    r_dbl  = {r_q, 1'b0};
    m_ext  = {2'b00, m_q};
    r_ge   = (r_dbl >= m_ext);
    r_next = r_ge ? RW'(r_dbl - m_ext) : r_dbl[RW-1:0];
  end

  // Next-state and datapath control; pulses default low, everything else holds.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    e_d     = e_q;
    m_d     = m_q;
    const_d = const_q;
    c_d     = c_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d     = P_in;
          e_d     = E_in;
          m_d     = M_in;
          code_d  = ERR_NONE;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        // Modulus validity outranks the operand range check.
        if (!m_q[0] || (m_q < WIDTH'(3))) begin
          code_d  = ERR_MOD;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (p_q >= m_q) begin
          code_d  = ERR_PGEM;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          r_d     = RW'(1);
          cnt_d   = '0;
          state_d = S_PRECOMP;
        end
      end

      S_PRECOMP: begin
        r_d = r_next;
        if (cnt_q == ITER_LAST) begin
          const_d = r_next[WIDTH-1:0];
          cnt_d   = '0;
          en_d    = 1'b1;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RUN: begin
        // eoc is checked first so it wins on the timeout cycle.
        if (rsa_eoc) begin
          c_d     = rsa_C;
          done_d  = 1'b1;
          en_d    = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          code_d  = ERR_TO;
          err_d   = 1'b1;
          en_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Operand, result, counter and status registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      p_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      const_q <= '0;
      c_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      p_q     <= p_d;
      e_q     <= e_d;
      m_q     <= m_d;
      const_q <= const_d;
      c_q     <= c_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign C_out     = c_q;
  assign rsa_en    = en_q;
  assign rsa_P     = p_q;
  assign rsa_E     = e_q;
  assign rsa_M     = m_q;
  assign rsa_Const = const_q;

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Bench for rsa_host_ctrl (WIDTH=8, TIMEOUT=16) with a behavioural rsa_unit responder.
// Directed steps only; every check is an immediate assertion against hand-computed values.
module tb_rsa_host_ctrl;

  logic       clk;
  logic       rstb;
  logic       start;
  logic [7:0] P_in, E_in, M_in;
  logic       busy, done, err;
  logic [1:0] err_code;
  logic [7:0] C_out;
  logic       rsa_en;
  logic [7:0] rsa_P, rsa_E, rsa_M, rsa_Const;
  logic [7:0] rsa_C;
  logic       rsa_eoc;

  int checks = 0;
  int errors = 0;

  // responder / monitor state
  int eoc_at   = 0;   // 0: never raise eoc, else raise on the n-th rsa_en cycle
  int en_cyc   = 0;
  int en_total = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int en_idle  = 0;

  rsa_host_ctrl #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rstb(rstb), .start(start),
    .P_in(P_in), .E_in(E_in), .M_in(M_in),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .C_out(C_out),
    .rsa_en(rsa_en), .rsa_P(rsa_P), .rsa_E(rsa_E), .rsa_M(rsa_M), .rsa_Const(rsa_Const),
    .rsa_C(rsa_C), .rsa_eoc(rsa_eoc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] modexp(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m);
    logic [15:0] acc;
    logic [15:0] base;
    if (m == 8'd0) return 8'd0;
    acc  = 16'd1;
    base = {8'd0, b} % {8'd0, m};
    for (int i = 7; i >= 0; i--) begin
      acc = (acc * acc) % {8'd0, m};
      if (e[i]) acc = (acc * base) % {8'd0, m};
    end
    return acc[7:0];
  endfunction

  // rsa_unit responder and pulse monitors, updated mid-cycle
  initial begin
    rsa_eoc = 1'b0;
    rsa_C   = 8'd0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
      if (rsa_en && !busy) en_idle++;
      if (rsa_en) begin
        en_total++;
        en_cyc++;
        rsa_eoc = (eoc_at != 0) && (en_cyc == eoc_at);
        rsa_C   = rsa_eoc ? modexp(rsa_P, rsa_E, rsa_M) : 8'd0;
      end else begin
        en_cyc  = 0;
        rsa_eoc = 1'b0;
        rsa_C   = 8'd0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m);
    P_in  = p;
    E_in  = e;
    M_in  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full successful op with cycle-exact checks; eoc arrives on RUN cycle 'lat'.
  task automatic full_op(input string tag, input logic [7:0] p, input logic [7:0] e, input logic [7:0] m,
                         input logic [7:0] c_exp, input logic [7:0] k_exp, input int lat);
    int en0, d0, e0;
    en0    = en_total;
    d0     = done_cnt;
    e0     = err_cnt;
    eoc_at = lat;
    do_start(p, e, m);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".P"}, rsa_P, p);
    chk({tag, ".E"}, rsa_E, e);
    chk({tag, ".M"}, rsa_M, m);
    repeat (20) tick();
    chk({tag, ".en_precomp"}, rsa_en, 0);
    tick();
    chk({tag, ".en_run"}, rsa_en, 1);
    chk({tag, ".const"}, rsa_Const, k_exp);
    repeat (lat - 1) tick();
    chk({tag, ".done_early"}, done, 0);
    chk({tag, ".en_wait"}, rsa_en, 1);
    tick();
    chk({tag, ".done"}, done, 1);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".busy_fall"}, busy, 0);
    chk({tag, ".c_out"}, C_out, c_exp);
    chk({tag, ".en_drop"}, rsa_en, 0);
    chk({tag, ".code"}, err_code, 0);
    tick();
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".en_cycles"}, en_total - en0, lat);
    chk({tag, ".done_cnt"}, done_cnt - d0, 1);
    chk({tag, ".err_cnt"}, err_cnt - e0, 0);
  endtask

  // Operand rejection in CHECK: err two cycles after start, no rsa_en.
  task automatic err_op(input string tag, input logic [7:0] p, input logic [7:0] m,
                        input logic [1:0] code, input logic [7:0] c_hold);
    int en0;
    en0 = en_total;
    do_start(p, 8'h03, m);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".err_early"}, err, 0);
    tick();
    chk({tag, ".err"}, err, 1);
    chk({tag, ".code"}, err_code, code);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".busy_fall"}, busy, 0);
    tick();
    chk({tag, ".err_pulse"}, err, 0);
    chk({tag, ".code_hold"}, err_code, code);
    chk({tag, ".c_hold"}, C_out, c_hold);
    chk({tag, ".no_en"}, en_total - en0, 0);
  endtask

  initial begin
    int d0, e0, en0;
    bit got;
    rstb  = 1'b0;
    start = 1'b0;
    P_in  = 8'd0;
    E_in  = 8'd0;
    M_in  = 8'd0;
    repeat (3) tick();

    // reset state
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.code", err_code, 0);
    chk("rst.c_out", C_out, 0);
    chk("rst.en", rsa_en, 0);
    chk("rst.P", rsa_P, 0);
    chk("rst.M", rsa_M, 0);
    chk("rst.const", rsa_Const, 0);
    rstb = 1'b1;
    repeat (2) tick();

    // 1: nominal op, 5^3 mod 197 = 0x7D, 2^20 mod 197 = 0x8E
    full_op("op1", 8'h05, 8'h03, 8'hC5, 8'h7D, 8'h8E, 5);

    // 2: even modulus
    err_op("even_m", 8'h05, 8'h10, 2'b01, 8'h7D);

    // 3: P>=M, P==M boundary, M<3, and modulus check priority
    err_op("p_ge_m", 8'hC8, 8'hC5, 2'b10, 8'h7D);
    err_op("p_eq_m", 8'hC5, 8'hC5, 2'b10, 8'h7D);
    err_op("m_one", 8'h00, 8'h01, 2'b01, 8'h7D);
    err_op("prio", 8'hC8, 8'h02, 2'b01, 8'h7D);

    // 4a: eoc never comes -> timeout after exactly 16 rsa_en cycles
    eoc_at = 0;
    en0    = en_total;
    do_start(8'h05, 8'h03, 8'hC5);
    repeat (21) tick();
    chk("to.en_start", rsa_en, 1);
    repeat (15) tick();
    chk("to.err_early", err, 0);
    chk("to.en_last", rsa_en, 1);
    tick();
    chk("to.err", err, 1);
    chk("to.code", err_code, 2'b11);
    chk("to.done", done, 0);
    chk("to.en_drop", rsa_en, 0);
    chk("to.busy_fall", busy, 0);
    chk("to.c_hold", C_out, 8'h7D);
    chk("to.en_cycles", en_total - en0, 16);
    tick();
    chk("to.err_pulse", err, 0);
    chk("to.code_hold", err_code, 2'b11);

    // 4b: eoc on the timeout cycle wins; 7^5 mod 197 = 0x3E
    full_op("to_eoc", 8'h07, 8'h05, 8'hC5, 8'h3E, 8'h8E, 16);

    // 5: start held while busy is ignored
    d0     = done_cnt;
    eoc_at = 5;
    do_start(8'h05, 8'h03, 8'hC5);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      start = busy;
      P_in  = 8'h11;
      E_in  = 8'h22;
      M_in  = 8'h33;
      tick();
      got = done;
    end
    start = 1'b0;
    chk("rpt.done_seen", got, 1);
    chk("rpt.c_out", C_out, 8'h7D);
    repeat (10) tick();
    chk("rpt.done_cnt", done_cnt - d0, 1);
    chk("rpt.busy", busy, 0);
    chk("rpt.P", rsa_P, 8'h05);
    chk("rpt.E", rsa_E, 8'h03);
    chk("rpt.M", rsa_M, 8'hC5);

    // 6a: reset during PRECOMP
    d0 = done_cnt;
    e0 = err_cnt;
    do_start(8'h05, 8'h03, 8'hC5);
    repeat (5) tick();
    chk("rstpc.busy_pre", busy, 1);
    rstb = 1'b0;
    #1;
    chk("rstpc.busy", busy, 0);
    chk("rstpc.P", rsa_P, 0);
    chk("rstpc.M", rsa_M, 0);
    chk("rstpc.c_out", C_out, 0);
    chk("rstpc.en", rsa_en, 0);
    repeat (2) tick();
    rstb = 1'b1;
    repeat (2) tick();

    // 6b: reset during RUN
    eoc_at = 0;
    do_start(8'h05, 8'h03, 8'hC5);
    repeat (21) tick();
    chk("rstrun.en_pre", rsa_en, 1);
    chk("rstrun.const_pre", rsa_Const, 8'h8E);
    repeat (3) tick();
    rstb = 1'b0;
    #1;
    chk("rstrun.en", rsa_en, 0);
    chk("rstrun.busy", busy, 0);
    chk("rstrun.const", rsa_Const, 0);
    chk("rstrun.code", err_code, 0);
    repeat (2) tick();
    rstb = 1'b1;
    repeat (2) tick();
    chk("rst.no_done", done_cnt - d0, 0);
    chk("rst.no_err", err_cnt - e0, 0);

    // 6c: normal op after resets
    full_op("op_after_rst", 8'h05, 8'h03, 8'hC5, 8'h7D, 8'h8E, 5);

    // global invariants
    chk("inv.done_and_err", both_cnt, 0);
    chk("inv.en_outside_run", en_idle, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
